// File: rtl/decoder_stage.sv
// Vector ASIP instruction decoder: instruction word -> write-back/store control, plus a sticky halt flag.
// Zero-cycle decode latency; no handshake or stall, a new word is decoded every cycle.

module decoder_stage #(
  parameter int registerSize = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             instruction,
  output logic                    MemoryWrite,
  output logic [1:0]              WriteRegFrom,
  output logic [3:0]              RegToWrite,
  output logic [registerSize-1:0] Immediate,
  output logic                    regWriteEnSc,
  output logic                    regWriteEnVec
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADDS = 4'h1;
  localparam logic [3:0] OP_SUBS = 4'h2;
  localparam logic [3:0] OP_ADDV = 4'h3;
  localparam logic [3:0] OP_SUBV = 4'h4;
  localparam logic [3:0] OP_MOVI = 4'h5;
  localparam logic [3:0] OP_LDV  = 4'h6;
  localparam logic [3:0] OP_STV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  typedef struct packed {
    logic                    mem_write;
    logic [1:0]              wb_sel;
    logic [3:0]              rd;
    logic [registerSize-1:0] imm;
    logic                    wen_sc;
    logic                    wen_vec;
  } ctrl_t;

  logic [3:0] opcode;
  logic       halted;
  ctrl_t      dec;
  ctrl_t      ctrl;

  assign opcode = instruction[15:12];

  // Reserved opcodes, NOP and HALT all fall through to the all-zero default.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADDS, OP_SUBS: begin
        dec.wen_sc = 1'b1;
        dec.wb_sel = WB_ALU;
        dec.rd     = instruction[3:0];
      end
      OP_ADDV, OP_SUBV: begin
        dec.wen_vec = 1'b1;
        dec.wb_sel  = WB_ALU;
        dec.rd      = instruction[3:0];
      end
      OP_MOVI: begin
        dec.wen_sc = 1'b1;
        dec.wb_sel = WB_IMM;
        dec.rd     = instruction[11:8];
        dec.imm    = registerSize'(instruction[7:0]);
      end
      OP_LDV: begin
        dec.wen_vec = 1'b1;
        dec.wb_sel  = WB_MEM;
        dec.rd      = instruction[3:0];
      end
      OP_STV: begin
        dec.mem_write = 1'b1;
      end
      OP_JMP: begin
        dec.imm = registerSize'(instruction[7:0]);
      end
      default: ;
    endcase
  end

  // Sticky until reset; reset takes priority over a HALT on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (opcode == OP_HALT) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    ctrl = dec;
    if (rst || halted) begin
      ctrl = '0;
    end
  end

  assign MemoryWrite   = ctrl.mem_write;
  assign WriteRegFrom  = ctrl.wb_sel;
  assign RegToWrite    = ctrl.rd;
  assign Immediate     = ctrl.imm;
  assign regWriteEnSc  = ctrl.wen_sc;
  assign regWriteEnVec = ctrl.wen_vec;

endmodule

// File: tb/tb_decoder_stage.sv
// Directed and swept checks of decoder_stage against a table-driven expectation queue.
module tb_decoder_stage;

  typedef struct packed {
    logic       mw;
    logic [1:0] wb;
    logic [3:0] rd;
    logic [7:0] imm;
    logic       sc;
    logic       vec;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic        MemoryWrite;
  logic [1:0]  WriteRegFrom;
  logic [3:0]  RegToWrite;
  logic [7:0]  Immediate;
  logic        regWriteEnSc;
  logic        regWriteEnVec;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  decoder_stage #(.registerSize(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .MemoryWrite  (MemoryWrite),
    .WriteRegFrom (WriteRegFrom),
    .RegToWrite   (RegToWrite),
    .Immediate    (Immediate),
    .regWriteEnSc (regWriteEnSc),
    .regWriteEnVec(regWriteEnVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam exp_t ZERO = '0;

  function automatic exp_t table_exp(input logic [15:0] ins);
    exp_t e;
    e = '0;
    case (ins[15:12])
      4'h1, 4'h2: begin e.sc = 1'b1; e.rd = ins[3:0]; end
      4'h3, 4'h4: begin e.vec = 1'b1; e.rd = ins[3:0]; end
      4'h5: begin e.sc = 1'b1; e.wb = 2'b10; e.rd = ins[11:8]; e.imm = ins[7:0]; end
      4'h6: begin e.vec = 1'b1; e.wb = 2'b01; e.rd = ins[3:0]; end
      4'h7: e.mw = 1'b1;
      4'h8: e.imm = ins[7:0];
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's stimulus away from the edge, queue its expectation, then compare.
  task automatic step(input logic r, input logic [15:0] ins, input exp_t e, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r;
    instruction = ins;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      x = sb_q.pop_front();
      check({tag, "_mw"},  {15'd0, MemoryWrite},   {15'd0, x.mw});
      check({tag, "_wb"},  {14'd0, WriteRegFrom},  {14'd0, x.wb});
      check({tag, "_rd"},  {12'd0, RegToWrite},    {12'd0, x.rd});
      check({tag, "_imm"}, {8'd0, Immediate},      {8'd0, x.imm});
      check({tag, "_sc"},  {15'd0, regWriteEnSc},  {15'd0, x.sc});
      check({tag, "_vec"}, {15'd0, regWriteEnVec}, {15'd0, x.vec});
      check({tag, "_excl"}, {15'd0, (regWriteEnSc && regWriteEnVec) ||
                                   (MemoryWrite && (regWriteEnSc || regWriteEnVec))}, 16'd0);
    end
  endtask

  initial begin
    exp_t e;
    logic [15:0] ins;

    rst = 1'b1;
    instruction = 16'h1234;
    step(1'b1, 16'h1234, ZERO, "reset0");
    step(1'b1, 16'h1234, ZERO, "reset1");
    e = '0; e.sc = 1'b1; e.rd = 4'd4;
    step(1'b0, 16'h1234, e, "adds_after_reset");

    e = '0; e.sc = 1'b1; e.wb = 2'b10; e.rd = 4'd2; e.imm = 8'hA7;
    step(1'b0, 16'h52A7, e, "movi");
    e = '0; e.vec = 1'b1; e.wb = 2'b01; e.rd = 4'd8;
    step(1'b0, 16'h6308, e, "ldv");
    e = '0; e.mw = 1'b1;
    step(1'b0, 16'h7120, e, "stv");
    e = '0; e.imm = 8'hFF;
    step(1'b0, 16'h80FF, e, "jmp");
    step(1'b0, 16'hB123, ZERO, "reserved_b");

    step(1'b0, 16'hF000, ZERO, "halt_cycle");
    step(1'b0, 16'h3459, ZERO, "halted0");
    step(1'b0, 16'h3459, ZERO, "halted1");
    step(1'b0, 16'h52A7, ZERO, "halted2");
    step(1'b0, 16'h7120, ZERO, "halted3");
    step(1'b1, 16'h3459, ZERO, "halt_rst");
    e = '0; e.vec = 1'b1; e.rd = 4'd9;
    step(1'b0, 16'h3459, e, "addv_after_halt");

    step(1'b1, 16'hF000, ZERO, "rst_halt_collide");
    e = '0; e.sc = 1'b1; e.rd = 4'd1;
    step(1'b0, 16'h1001, e, "adds_after_collide");

    for (int rep = 0; rep < 3; rep++) begin
      for (int op = 0; op < 15; op++) begin
        ins = {op[3:0], 12'($urandom_range(0, 4095))};
        step(1'b0, ins, table_exp(ins), $sformatf("sweep_op%0h", op));
      end
    end
    step(1'b0, 16'hFABC, ZERO, "sweep_opf");
    step(1'b0, 16'h1235, ZERO, "sweep_after_halt");
    step(1'b1, 16'h1235, ZERO, "final_rst");
    e = '0; e.sc = 1'b1; e.rd = 4'd5;
    step(1'b0, 16'h1235, e, "final_adds");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_stage.md
# decoder_stage

Combinational instruction decoder for the 16-bit vector ASIP pipeline, with one registered halt flag. It sits between the fetch/decode pipeline register and the decode/execute pipeline register. It turns the 16-bit instruction word into write-back control, memory-write control, the destination register index and the immediate value. Register-file read selects come straight from instruction bits [11:8] and [7:4] outside this block.

## Interface
- registerSize, default 8: width of the Immediate output, in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- instruction  input  16  decoded word; opcode is [15:12].
- MemoryWrite  output  1  the instruction stores a vector to data memory.
- WriteRegFrom  output  2  write-back source select:
  - 00 = ALU result
  - 01 = data memory
  - 10 = immediate
  - 11 = reserved, never driven
- RegToWrite  output  4  destination register index.
- Immediate  output  registerSize  immediate value, zero-extended or truncated from instruction[7:0].
- regWriteEnSc  output  1  write enable for the scalar register file.
- regWriteEnVec  output  1  write enable for the vector register file.

## Operation
- Default for every output is 0. Each opcode drives only the fields listed for it.
- 0x0 NOP: all outputs 0.
- 0x1 ADDS and 0x2 SUBS (scalar ALU): regWriteEnSc=1, WriteRegFrom=00, RegToWrite=instruction[3:0].
- 0x3 ADDV and 0x4 SUBV (vector ALU): regWriteEnVec=1, WriteRegFrom=00, RegToWrite=instruction[3:0].
- 0x5 MOVI (scalar immediate): regWriteEnSc=1, WriteRegFrom=10, RegToWrite=instruction[11:8], Immediate=instruction[7:0].
- 0x6 LDV (vector load):
  - regWriteEnVec=1, WriteRegFrom=01, RegToWrite=instruction[3:0].
  - Address comes from operand [11:8] via the execute stage. Immediate=0.
- 0x7 STV (vector store): MemoryWrite=1; no register write enable; RegToWrite=0.
- 0x8 JMP: Immediate=instruction[7:0] (jump target, consumed downstream); no enables asserted.
- 0xF HALT: all outputs 0; sets the halt flag.
- 0x9–0xE: reserved; decode exactly as NOP.
- Halt flag:
  - While set, every output is 0 regardless of instruction.
  - Only rst clears it.
- While rst=1, every output is forced to 0 in the same cycle, regardless of instruction and halt flag.
- At most one of regWriteEnSc and regWriteEnVec is ever 1.
- MemoryWrite=1 never coincides with either register write enable.

## Timing
- Decode is purely combinational: zero-cycle latency from instruction to outputs.
- Halt flag:
  - Set at a rising edge where rst=0 and instruction[15:12]=0xF.
  - Cleared at any rising edge where rst=1.
  - Reset value is 0.
- Cycle containing HALT: outputs already 0 because HALT decodes to all-zero. From the next edge, all outputs are held at 0.
- rst and HALT asserted on the same edge: rst wins; the flag ends the cycle cleared.
- Reset mid-operation: outputs go to 0 combinationally while rst=1. Normal decode resumes in the first cycle with rst=0.
- No handshake and no stall input. A new instruction is decoded every cycle.

## Test plan
- Reset: assert rst for 2 cycles with instruction=0x1234, then deassert -> all outputs 0 during reset; afterwards RegToWrite=4, regWriteEnSc=1, WriteRegFrom=00.
- Immediate and vector load:
  - instruction=0x52A7 -> regWriteEnSc=1, WriteRegFrom=10, RegToWrite=2, Immediate=0xA7.
  - instruction=0x6308 -> regWriteEnVec=1, WriteRegFrom=01, RegToWrite=8, Immediate=0.
- Store, jump and reserved:
  - instruction=0x7120 -> MemoryWrite=1, both enables 0.
  - instruction=0x80FF -> Immediate=0xFF, all enables 0.
  - instruction=0xB123 -> all outputs 0.
- Halt: apply 0xF000 for one cycle, then 0x3459 -> outputs stay 0 on every subsequent cycle. Pulse rst -> 0x3459 then decodes to regWriteEnVec=1, RegToWrite=9.
- Reset/halt collision: rst=1 with instruction=0xF000 on the same edge, then rst=0 with 0x1001 -> regWriteEnSc=1, RegToWrite=1 (flag not set).
- Exhaustive sweep of all 16 opcodes with random low 12 bits -> outputs match the table above; never two enables high together.
